// File: rtl/median_window_filter.sv
// Streaming sliding-window median filter: keeps the last DEPTH samples in arrival
// and sorted order, updating the sorted window with one evict/insert per accepted sample.
module median_window_filter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [WIDTH-1:0]       out_min,
    output logic [WIDTH-1:0]       out_max,
    output logic [DEPTH*WIDTH-1:0] out_sorted,
    output logic [CW-1:0]          fill_count
);

    localparam logic [WIDTH-1:0] SENTINEL = '1;
    localparam logic [CW-1:0]    FULL     = CW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] hist_p1;
    logic [DEPTH-1:0][WIDTH-1:0] srt_p1;
    logic [DEPTH-1:0][WIDTH-1:0] srt_p0;
    logic [DEPTH-2:0][WIDTH-1:0] kept_p0;
    logic [DEPTH-2:0]            lt_p0;
    logic [WIDTH-1:0]            victim_p0;
    logic [CW-1:0]               fill_next_p0;
    logic                        hit_p0;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == FULL) ? c : c + CW'(1);
    endfunction

    // Stage p0: remove the first copy of the victim, then insert in_data in order.
    // Unfilled slots hold the sentinel, so evicting a sentinel drops one padding slot.
    always_comb begin
        victim_p0    = (fill_count == FULL) ? hist_p1[DEPTH-1] : SENTINEL;
        fill_next_p0 = sat_inc(fill_count);
        hit_p0       = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            hit_p0     = hit_p0 | (srt_p1[i] == victim_p0);
            kept_p0[i] = hit_p0 ? srt_p1[i+1] : srt_p1[i];
            lt_p0[i]   = kept_p0[i] < in_data;
        end
        srt_p0[0] = lt_p0[0] ? kept_p0[0] : in_data;
        for (int i = 1; i < DEPTH - 1; i++) begin
            srt_p0[i] = lt_p0[i] ? kept_p0[i] : (lt_p0[i-1] ? in_data : kept_p0[i-1]);
        end
        srt_p0[DEPTH-1] = lt_p0[DEPTH-2] ? in_data : kept_p0[DEPTH-2];
    end

    // Stage p1: registered window state and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_p1    <= '0;
            srt_p1     <= '1;
            fill_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_min    <= '0;
            out_max    <= '0;
        end else if (clear) begin
            hist_p1    <= '0;
            srt_p1     <= '1;
            fill_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_min    <= '0;
            out_max    <= '0;
        end else if (in_valid) begin
            hist_p1    <= {hist_p1[DEPTH-2:0], in_data};
            srt_p1     <= srt_p0;
            fill_count <= fill_next_p0;
            out_valid  <= (fill_next_p0 == FULL);
            out_data   <= srt_p0[DEPTH/2];
            out_min    <= srt_p0[0];
            out_max    <= srt_p0[DEPTH-1];
        end else begin
            out_valid  <= 1'b0;
        end
    end

    assign out_sorted = srt_p1;

endmodule

// File: tb/tb_median_window_filter.sv
// Directed bench: hand-computed vectors at DEPTH=5, reference-sort model at DEPTH=3 and 15.
module tb_median_window_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        clear5, vld5;
    logic [7:0]  din5;
    logic        ov5;
    logic [7:0]  od5, omn5, omx5;
    logic [39:0] os5;
    logic [2:0]  fc5;

    logic        clearw, vldw;
    logic [11:0] dinw;
    logic        ov3, ov15;
    logic [11:0] od3, omn3, omx3, od15, omn15, omx15;
    logic [35:0] os3;
    logic [179:0] os15;
    logic [1:0]  fc3;
    logic [3:0]  fc15;

    int checks = 0;
    int errors = 0;

    int q3[$];
    int q15[$];
    logic         e3v, e15v;
    logic [11:0]  e3d, e3mn, e3mx, e15d, e15mn, e15mx;
    logic [35:0]  e3s;
    logic [179:0] e15s;
    int           srt[15];

    int vec[24] = '{100, 4095, 7, 100, 0, 2048, 7, 7, 300, 4095, 1, 99,
                    100, 5, 6, 4095, 0, 12, 12, 3000, 7, 8, 9, 10};

    median_window_filter #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .clear(clear5), .in_valid(vld5), .in_data(din5),
        .out_valid(ov5), .out_data(od5), .out_min(omn5), .out_max(omx5),
        .out_sorted(os5), .fill_count(fc5)
    );

    median_window_filter #(.WIDTH(12), .DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .clear(clearw), .in_valid(vldw), .in_data(dinw),
        .out_valid(ov3), .out_data(od3), .out_min(omn3), .out_max(omx3),
        .out_sorted(os3), .fill_count(fc3)
    );

    median_window_filter #(.WIDTH(12), .DEPTH(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .clear(clearw), .in_valid(vldw), .in_data(dinw),
        .out_valid(ov15), .out_data(od15), .out_min(omn15), .out_max(omx15),
        .out_sorted(os15), .fill_count(fc15)
    );

    task automatic chk(input string tag, input logic [179:0] obs, input logic [179:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] pk5(input logic [7:0] a0, a1, a2, a3, a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    task automatic s5(input bit v, input logic [7:0] d, input bit c);
        clear5 = c;
        vld5   = v;
        din5   = d;
        tick();
        clear5 = 1'b0;
        vld5   = 1'b0;
    endtask

    task automatic chk5(input string tag, input logic v, input logic [2:0] fc,
                        input logic [39:0] s, input logic [7:0] d, mn, mx);
        chk({tag, "_valid"}, 180'(ov5), 180'(v));
        chk({tag, "_fill"}, 180'(fc5), 180'(fc));
        chk({tag, "_sorted"}, 180'(os5), 180'(s));
        chk({tag, "_median"}, 180'(od5), 180'(d));
        chk({tag, "_min"}, 180'(omn5), 180'(mn));
        chk({tag, "_max"}, 180'(omx5), 180'(mx));
    endtask

    function automatic void ref_sort(input int q[$], input int depth, output int s[15]);
        int t;
        for (int i = 0; i < 15; i++) s[i] = (i < depth) ? ((i < q.size()) ? q[i] : 4095) : 0;
        for (int i = 0; i < depth; i++)
            for (int j = 0; j < depth - 1 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
    endfunction

    task automatic model_reset();
        q3.delete();
        q15.delete();
        e3v = 1'b0; e3d = '0; e3mn = '0; e3mx = '0; e3s = '1;
        e15v = 1'b0; e15d = '0; e15mn = '0; e15mx = '0; e15s = '1;
    endtask

    task automatic ws(input bit c, input bit v, input int d);
        clearw = c;
        vldw   = v;
        dinw   = d[11:0];
        tick();
        clearw = 1'b0;
        vldw   = 1'b0;
        if (c) begin
            model_reset();
        end else if (v) begin
            q3.push_back(d);
            if (q3.size() > 3) void'(q3.pop_front());
            ref_sort(q3, 3, srt);
            for (int i = 0; i < 3; i++) e3s[i*12 +: 12] = srt[i][11:0];
            e3d = srt[1][11:0]; e3mn = srt[0][11:0]; e3mx = srt[2][11:0];
            e3v = (q3.size() == 3);
            q15.push_back(d);
            if (q15.size() > 15) void'(q15.pop_front());
            ref_sort(q15, 15, srt);
            for (int i = 0; i < 15; i++) e15s[i*12 +: 12] = srt[i][11:0];
            e15d = srt[7][11:0]; e15mn = srt[0][11:0]; e15mx = srt[14][11:0];
            e15v = (q15.size() == 15);
        end else begin
            e3v  = 1'b0;
            e15v = 1'b0;
        end
        chk("d3_valid", 180'(ov3), 180'(e3v));
        chk("d3_fill", 180'(fc3), 180'(q3.size()));
        chk("d3_sorted", 180'(os3), 180'(e3s));
        chk("d3_median", 180'(od3), 180'(e3d));
        chk("d3_min", 180'(omn3), 180'(e3mn));
        chk("d3_max", 180'(omx3), 180'(e3mx));
        chk("d15_valid", 180'(ov15), 180'(e15v));
        chk("d15_fill", 180'(fc15), 180'(q15.size()));
        chk("d15_sorted", os15, e15s);
        chk("d15_median", 180'(od15), 180'(e15d));
        chk("d15_min", 180'(omn15), 180'(e15mn));
        chk("d15_max", 180'(omx15), 180'(e15mx));
    endtask

    initial begin
        rst_n = 1'b0;
        clear5 = 1'b0; vld5 = 1'b0; din5 = '0;
        clearw = 1'b0; vldw = 1'b0; dinw = '0;
        model_reset();
        #12;
        chk5("reset", 1'b0, 3'd0, '1, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        s5(1, 8'd8, 0);
        s5(1, 8'd12, 0);
        s5(1, 8'd10, 0);
        chk5("fill3", 1'b0, 3'd3, pk5(8, 10, 12, 255, 255), 8'd12, 8'd8, 8'd255);
        s5(1, 8'd5, 0);
        chk5("fill4", 1'b0, 3'd4, pk5(5, 8, 10, 12, 255), 8'd10, 8'd5, 8'd255);
        s5(1, 8'd14, 0);
        chk5("full", 1'b1, 3'd5, pk5(5, 8, 10, 12, 14), 8'd10, 8'd5, 8'd14);

        vld5 = 1'b1; din5 = 8'd3; tick();
        chk5("slide3", 1'b1, 3'd5, pk5(3, 5, 10, 12, 14), 8'd10, 8'd3, 8'd14);
        din5 = 8'd10; tick();
        chk5("slide10", 1'b1, 3'd5, pk5(3, 5, 10, 10, 14), 8'd10, 8'd3, 8'd14);
        din5 = 8'd7; tick();
        chk5("slide7", 1'b1, 3'd5, pk5(3, 5, 7, 10, 14), 8'd7, 8'd3, 8'd14);
        vld5 = 1'b0; tick();
        chk5("idle_hold", 1'b0, 3'd5, pk5(3, 5, 7, 10, 14), 8'd7, 8'd3, 8'd14);

        s5(1, 8'd255, 0);
        chk5("sent_a", 1'b1, 3'd5, pk5(3, 7, 10, 14, 255), 8'd10, 8'd3, 8'd255);
        s5(0, 8'd0, 0);
        chk5("gap_a", 1'b0, 3'd5, pk5(3, 7, 10, 14, 255), 8'd10, 8'd3, 8'd255);
        s5(1, 8'd255, 0);
        s5(0, 8'd0, 0);
        s5(1, 8'd0, 0);
        chk5("sent_c", 1'b1, 3'd5, pk5(0, 7, 10, 255, 255), 8'd10, 8'd0, 8'd255);
        s5(0, 8'd0, 0);
        s5(1, 8'd255, 0);
        s5(0, 8'd0, 0);
        s5(1, 8'd1, 0);
        chk5("sent_end", 1'b1, 3'd5, pk5(0, 1, 255, 255, 255), 8'd255, 8'd0, 8'd255);

        s5(1, 8'd9, 1);
        chk5("clear", 1'b0, 3'd0, '1, 8'd0, 8'd0, 8'd0);
        s5(1, 8'd1, 0);
        s5(1, 8'd2, 0);
        s5(1, 8'd3, 0);
        s5(1, 8'd4, 0);
        chk5("refill4", 1'b0, 3'd4, pk5(1, 2, 3, 4, 255), 8'd3, 8'd1, 8'd255);
        s5(1, 8'd5, 0);
        chk5("refill5", 1'b1, 3'd5, pk5(1, 2, 3, 4, 5), 8'd3, 8'd1, 8'd5);

        #2;
        rst_n = 1'b0;
        #1;
        chk5("async_rst", 1'b0, 3'd0, '1, 8'd0, 8'd0, 8'd0);
        rst_n = 1'b1;
        s5(1, 8'd20, 0);
        s5(1, 8'd21, 0);
        s5(1, 8'd22, 0);
        s5(1, 8'd23, 0);
        chk5("post_rst4", 1'b0, 3'd4, pk5(20, 21, 22, 23, 255), 8'd22, 8'd20, 8'd255);
        s5(1, 8'd24, 0);
        chk5("post_rst5", 1'b1, 3'd5, pk5(20, 21, 22, 23, 24), 8'd22, 8'd20, 8'd24);

        for (int k = 0; k < 24; k++) begin
            ws(0, 1, vec[k]);
            if (k % 7 == 6) ws(0, 0, 0);
        end
        ws(1, 1, 77);
        for (int k = 0; k < 16; k++) ws(0, 1, vec[23-k]);
        ws(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/median_window_filter.md
Name: median_window_filter

Overview:
- Streaming sliding-window median filter, the sequential successor to the combinational 5-input median/sort block.
- Keeps the last DEPTH accepted samples in arrival order and in sorted order.
- On each accepted sample it evicts the oldest, inserts the new one, and presents the sorted window, median, min and max one cycle later.
- Sits on pixel/sample streams ahead of downstream processing.

Parameters:
- WIDTH, 8, sample width in bits (unsigned).
- DEPTH, 5, window length; odd, 3..15.
- CW, $clog2(DEPTH+1), width of fill_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of the window.
- in_valid  input  1  sample strobe; no backpressure, every strobe accepted.
- in_data  input  WIDTH  unsigned sample.
- out_valid  output  1  one-cycle pulse; window full and updated.
- out_data  output  WIDTH  median (sorted index DEPTH/2).
- out_min  output  WIDTH  sorted index 0.
- out_max  output  WIDTH  sorted index DEPTH-1.
- out_sorted  output  DEPTH*WIDTH  ascending sorted window; index 0 at bits [WIDTH-1:0].
- fill_count  output  CW  number of real samples held, 0..DEPTH.

Behaviour:
- State:
  - hist[0..DEPTH-1]: arrival-order shift register; hist[0] newest.
  - srt[0..DEPTH-1]: ascending sorted array.
  - fill_count.
- Reset (async, rst_n=0):
  - hist = 0; srt all = {WIDTH{1'b1}} (sentinel).
  - fill_count = 0; out_valid = 0.
  - out_data = out_min = out_max = 0.
- Accept, on the clk edge with in_valid=1 and clear=0:
  - Victim value V = hist[DEPTH-1] if fill_count==DEPTH, else the sentinel {WIDTH{1'b1}}.
  - srt_next = srt with exactly one instance of V removed and in_data inserted, kept ascending.
  - Single-cycle parallel compare/shift network; no iteration.
  - hist shifts: hist[0] <= in_data.
  - fill_count increments, saturating at DEPTH.
- Outputs are registered and updated on the accept edge, visible the cycle after in_valid.
  - out_sorted = srt_next.
  - out_data = srt_next[DEPTH/2]; out_min = srt_next[0]; out_max = srt_next[DEPTH-1].
- out_valid = 1 for exactly one cycle after an accept whose resulting fill_count==DEPTH; 0 otherwise.
- Latency: 1 cycle. Throughput: one sample per cycle, back-to-back.
- in_valid=0: all state and outputs hold; out_valid = 0.
- During fill (fill_count<DEPTH):
  - out_sorted shows real samples ascending, followed by sentinels.
  - out_valid stays 0, but out_data/out_min/out_max still track srt_next.
- Duplicates: removal deletes one instance only. Equal values are interchangeable, so a real sample equal to the sentinel (all ones) produces the correct multiset.
- clear=1 at an edge: same values as reset, applied synchronously. clear has priority over a simultaneous in_valid, and that sample is dropped.
- Async reset mid-stream: immediate return to reset values; next accepted sample starts a fresh fill.
- All comparisons unsigned; no arithmetic, no width growth.

Test Plan:
- Fill (WIDTH=8, DEPTH=5): after reset, samples 8, 12, 10 -> fill_count=3, out_valid=0, out_sorted = 8, 10, 12, 255, 255.
- Full window: continue with 5, 14 -> on the cycle after 14: out_valid=1, out_sorted = 5, 8, 10, 12, 14, out_data=10, out_min=5, out_max=14.
- Sliding with duplicates: continue back-to-back with 3, 10, 7.
  - After 3 (evicts 8): sorted 3, 5, 10, 12, 14; median 10.
  - After 10 (evicts 12): sorted 3, 5, 10, 10, 14; median 10.
  - After 7 (evicts 10): sorted 3, 5, 7, 10, 14; median 7.
  - out_valid high on each of the three cycles.
- Gaps and sentinel-valued data: interleave idle cycles between 255, 255, 0, 255, 1 -> outputs hold during gaps; after the last sample sorted = 0, 1, 255, 255, 255, median 255, out_valid=1.
- Clear priority: with a full window, assert clear together with in_valid=9 -> next cycle fill_count=0, out_valid=0, all sorted entries 255; then 5 more samples are needed before out_valid returns.
- Async reset mid-stream: drop rst_n between clock edges -> outputs go to reset values immediately without a clock edge; after release, the stream refills from empty.
- Repeat the full-window, sliding and clear-priority scenarios at DEPTH=3 and DEPTH=15, WIDTH=12, checking results against a behavioural reference sort.
